ids_dma: RTL and testbench
==========================

# ids_dma

Single-channel word-copy DMA engine that is the initiator on the bus's DMA master port: it raises a request, waits for grant under the core-first priority arbiter, and issues read-then-write word transfers through the shared DMEM port. The core programs it through a small memory-mapped register slave port, which has the same shape as the UART slave port. It reports completion through a status bit and a level interrupt.

## Interface
Parameters:
- LEN_W, 16, width of the transfer length register in words.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- o_req  out  1  bus request to arbiter
- i_gnt  in  1  bus grant from arbiter
- o_bus_addr  out  32  bus byte address, always word-aligned
- o_bus_write  out  1  bus write strobe
- o_bus_read  out  1  bus read strobe
- o_bus_size  out  4  byte enables, fixed 4'b1111
- o_bus_din  out  32  write data to DMEM
- i_bus_dout  in  32  read data from DMEM, valid the cycle after an accepted read
- i_cfg_addr  in  32  register address; only bits [3:2] are decoded
- i_cfg_write  in  1  register write strobe
- i_cfg_read  in  1  register read strobe
- i_cfg_size  in  4  ignored; registers are word-only
- i_cfg_din  in  32  register write data
- o_cfg_dout  out  32  register read data, registered
- o_irq  out  1  level interrupt, equal to the DONE flag

## Operation
Register map (offsets):
- 0x0 SRC: source byte address, read/write. Bits [1:0] are forced to 0.
- 0x4 DST: destination byte address, read/write. Bits [1:0] are forced to 0.
- 0x8 LEN: word count in bits [LEN_W-1:0], read/write. Upper bits read 0.
- 0xC CTRL/STATUS:
  - Write bit0=1: START.
  - Write bit1=1: clear DONE (write-1-to-clear).
  - Read bit0: BUSY. Read bit1: DONE. Other bits read 0.

Register write rules:
- Writes to SRC, DST or LEN while BUSY are ignored.
- START while BUSY is ignored.
- A write with both START=1 and clear-DONE=1 clears DONE and then starts.

Working state:
- START copies SRC, DST and LEN into working counters: src_q, dst_q, cnt_q.
- Programmed registers are not modified by a transfer.
- START also clears DONE.

FSM states:
- IDLE
  - On START with LEN==0: set DONE and stay in IDLE; no bus access.
  - On START with LEN!=0: go to RD.
- RD
  - o_req=1, o_bus_read=1, o_bus_addr=src_q.
  - On i_gnt=1 (transfer accepted): go to RWAIT.
- RWAIT
  - o_req=0, both strobes 0.
  - Capture i_bus_dout into buf_q, then go to WR.
- WR
  - o_req=1, o_bus_write=1, o_bus_addr=dst_q, o_bus_din=buf_q.
  - On i_gnt=1: src_q+=4, dst_q+=4, cnt_q-=1.
  - If cnt_q was 1: set DONE and go to IDLE; otherwise go to RD.

Bus-side rules:
- BUSY = (state != IDLE).
- In IDLE and RWAIT: o_req, o_bus_read and o_bus_write are 0.
- In RD and WR: address, strobes and data are held stable while i_gnt=0. The arbiter may withhold or drop grant in any cycle; the engine simply waits.
- Address arithmetic is modulo 2^32: 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
- Overlapping source and destination ranges are copied ascending, word by word, with no hazard protection.

Register read port:
- o_cfg_dout is updated on the edge where i_cfg_read=1, from the decoded register.
- It holds its value otherwise.

## Timing
- Reset (asynchronous): state=IDLE; SRC/DST/LEN/working registers/buf_q=0; DONE=0.
  - Outputs during reset: o_req=0, o_bus_read=0, o_bus_write=0, o_bus_addr=0, o_bus_din=0, o_cfg_dout=0, o_irq=0, o_bus_size=4'b1111.
- Reset mid-transfer: o_req drops immediately (asynchronously); no further bus activity after release.
- START write at edge T: state=RD and o_req=1 from cycle T+1.
- Per word with continuous grant: 3 cycles (RD, RWAIT, WR).
- LEN=N with continuous grant: BUSY for exactly 3N cycles. DONE/o_irq rise on the edge that accepts the final write.
- Each cycle of withheld grant in RD or WR adds one cycle.
- Register read returns data on the cycle after i_cfg_read.
- DONE clear via CTRL write takes effect on that edge. A clear coincident with DONE being set: the set wins.

## Test plan
- Reset then read all four registers -> each returns 0; o_req=0; o_irq=0.
- SRC=0x1000, DST=0x1100, LEN=4, START, gnt tied 1 -> bus sequence:
  - R 0x1000, W 0x1100, R 0x1004, W 0x1104, …, through 0x110C.
  - Destination words equal source words; BUSY for 12 cycles; o_irq=1.
- Same setup with gnt held low for 5 cycles during the first RD and for 2 cycles during the second WR -> address and strobes stay stable while waiting; completes in 19 cycles; data correct.
- LEN=0, START -> DONE=1 the next cycle; o_req never asserted. Then write CTRL=0x2 -> DONE=0 and o_irq=0.
- While BUSY:
  - Write SRC=0x2000 and re-START -> both ignored; the transfer finishes with the original addresses; SRC reads back the old value.
- SRC=0xFFFF_FFFC, LEN=2 -> the second read address is 0x0000_0000.
- Assert i_rst_n=0 during a WR with gnt low -> o_req=0 immediately. After release: BUSY=0 and no bus activity.

Source files
------------

// File: rtl/ids_dma.sv
// ids_dma: single-channel word-copy DMA engine.
//
// The core programs SRC/DST/LEN through a word-only register slave port, then writes START.
// The engine copies LEN words ascending from SRC to DST. Each word is one read followed by
// one write on the shared DMEM bus. Each access is requested from the arbiter and held
// stable until granted. Completion sets DONE, which also drives the level interrupt.
//
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   o_req / i_gnt       bus request to / grant from the arbiter
//   o_bus_addr          word-aligned byte address
//   o_bus_read/write    bus strobes
//   o_bus_size          byte enables, always all four
//   o_bus_din           write data toward DMEM
//   i_bus_dout          DMEM read data, valid the cycle after an accepted read
//   i_cfg_*             register slave port (offsets 0x0 SRC, 0x4 DST, 0x8 LEN, 0xC CTRL)
//   o_cfg_dout          registered read data
//   o_irq               level interrupt, equal to DONE
module ids_dma #(
  parameter int unsigned LEN_W = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_req,
  input  logic        i_gnt,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_write,
  output logic        o_bus_read,
  output logic [3:0]  o_bus_size,
  output logic [31:0] o_bus_din,
  input  logic [31:0] i_bus_dout,
  input  logic [31:0] i_cfg_addr,
  input  logic        i_cfg_write,
  input  logic        i_cfg_read,
  input  logic [3:0]  i_cfg_size,
  input  logic [31:0] i_cfg_din,
  output logic [31:0] o_cfg_dout,
  output logic        o_irq
);

  typedef enum logic [1:0] {StIdle, StRd, StRwait, StWr} state_e;

  state_e             state_q, state_d;
  logic [31:0]        src_reg_q, dst_reg_q;
  logic [LEN_W-1:0]   len_reg_q;
  logic [31:0]        src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        buf_q, buf_d;
  logic               done_q, done_d;
  logic               req_q, rd_q, wr_q;
  logic [31:0]        addr_q, din_q, cfg_dout_q;

  logic [1:0]         cfg_sel;
  logic               busy, ctrl_wr, start, clr_done;
  logic [31:0]        cfg_rdata;

  // Only word offsets are decoded and size is ignored.
  logic cfg_unused;
  assign cfg_unused = ^{i_cfg_size, i_cfg_addr[31:4], i_cfg_addr[1:0]};

  assign cfg_sel  = i_cfg_addr[3:2];
  assign busy     = (state_q != StIdle);
  assign ctrl_wr  = i_cfg_write && (cfg_sel == 2'd3);
  assign start    = ctrl_wr && i_cfg_din[0] && !busy;
  assign clr_done = ctrl_wr && i_cfg_din[1];

  // Next-state logic for the transfer engine and DONE.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    done_d  = done_q;
    if (clr_done) done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d  = src_reg_q;
          dst_d  = dst_reg_q;
          cnt_d  = len_reg_q;
          done_d = 1'b0;
          if (len_reg_q == '0) done_d = 1'b1;
          else                 state_d = StRd;
        end
      end
      StRd: begin
        if (i_gnt) state_d = StRwait;
      end
      StRwait: begin
        buf_d   = i_bus_dout;
        state_d = StWr;
      end
      StWr: begin
        if (i_gnt) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          cnt_d = cnt_q - LEN_W'(1);
          // Set has priority over a coincident clear.
          if (cnt_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StRd;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_sel)
      2'd0: cfg_rdata = src_reg_q;
      2'd1: cfg_rdata = dst_reg_q;
      2'd2: cfg_rdata = 32'(len_reg_q);
      2'd3: cfg_rdata = {30'd0, done_q, busy};
      default: cfg_rdata = '0;
    endcase
  end

  // Bus outputs are registered from the next state so they change only on clock edges
  // and stay stable while the arbiter withholds grant.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      src_reg_q  <= '0;
      dst_reg_q  <= '0;
      len_reg_q  <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      buf_q      <= '0;
      done_q     <= 1'b0;
      req_q      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      cfg_dout_q <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
      req_q   <= (state_d == StRd) || (state_d == StWr);
      rd_q    <= (state_d == StRd);
      wr_q    <= (state_d == StWr);
      if (state_d == StRd) begin
        addr_q <= src_d;
      end else if (state_d == StWr) begin
        addr_q <= dst_d;
        din_q  <= buf_d;
      end
      if (i_cfg_write && !busy) begin
        unique case (cfg_sel)
          2'd0: src_reg_q <= {i_cfg_din[31:2], 2'b00};
          2'd1: dst_reg_q <= {i_cfg_din[31:2], 2'b00};
          2'd2: len_reg_q <= i_cfg_din[LEN_W-1:0];
          default: ;
        endcase
      end
      if (i_cfg_read) cfg_dout_q <= cfg_rdata;
    end
  end

  assign o_req       = req_q;
  assign o_bus_read  = rd_q;
  assign o_bus_write = wr_q;
  assign o_bus_addr  = addr_q;
  assign o_bus_din   = din_q;
  assign o_bus_size  = 4'b1111;
  assign o_cfg_dout  = cfg_dout_q;
  assign o_irq       = done_q;

endmodule

// File: tb/tb_ids_dma.sv
// Self-checking bench for ids_dma. A bus monitor records every granted access and models
// DMEM reads with a fixed address-derived pattern. Scenario tasks push the accesses they
// expect into a scoreboard queue and compare them against the recorded ones.
module tb_ids_dma;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } xact_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        o_req;
  logic        i_gnt;
  logic [31:0] o_bus_addr;
  logic        o_bus_write;
  logic        o_bus_read;
  logic [3:0]  o_bus_size;
  logic [31:0] o_bus_din;
  logic [31:0] i_bus_dout = '0;
  logic [31:0] i_cfg_addr;
  logic        i_cfg_write;
  logic        i_cfg_read;
  logic [3:0]  i_cfg_size;
  logic [31:0] i_cfg_din;
  logic [31:0] o_cfg_dout;
  logic        o_irq;

  int    n_cmp  = 0;
  int    n_fail = 0;
  int    obs_rd = 0;
  xact_t exp_q[$];
  xact_t obs_q[$];

  ids_dma #(.LEN_W(16)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .o_req       (o_req),
    .i_gnt       (i_gnt),
    .o_bus_addr  (o_bus_addr),
    .o_bus_write (o_bus_write),
    .o_bus_read  (o_bus_read),
    .o_bus_size  (o_bus_size),
    .o_bus_din   (o_bus_din),
    .i_bus_dout  (i_bus_dout),
    .i_cfg_addr  (i_cfg_addr),
    .i_cfg_write (i_cfg_write),
    .i_cfg_read  (i_cfg_read),
    .i_cfg_size  (i_cfg_size),
    .i_cfg_din   (i_cfg_din),
    .o_cfg_dout  (o_cfg_dout),
    .o_irq       (o_irq)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] src_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_3c3c;
  endfunction

  // DMEM model and bus recorder.
  always @(posedge i_clk) begin
    if (o_req && i_gnt) begin
      obs_q.push_back('{wr: o_bus_write, addr: o_bus_addr,
                        data: (o_bus_write ? o_bus_din : 32'h0)});
      if (o_bus_read) i_bus_dout <= src_word(o_bus_addr);
    end
  end

  task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge i_clk);
    i_cfg_addr  = a;
    i_cfg_din   = d;
    i_cfg_write = 1'b1;
    @(negedge i_clk);
    i_cfg_write = 1'b0;
  endtask

  task automatic cfg_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge i_clk);
    i_cfg_addr = a;
    i_cfg_read = 1'b1;
    @(negedge i_clk);
    i_cfg_read = 1'b0;
    d = o_cfg_dout;
  endtask

  task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{wr: 1'b0, addr: s + 32'(4 * i), data: 32'h0});
      exp_q.push_back('{wr: 1'b1, addr: d + 32'(4 * i), data: src_word(s + 32'(4 * i))});
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!o_irq && cyc < 200) begin
      @(negedge i_clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    i_rst_n = 1'b0; i_gnt = 1'b0; i_cfg_addr = '0; i_cfg_write = 1'b0;
    i_cfg_read = 1'b0; i_cfg_size = 4'hf; i_cfg_din = '0;
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if ({o_req, o_bus_read, o_bus_write, o_bus_addr, o_bus_din, o_cfg_dout, o_irq, o_bus_size}
        !== {3'b000, 32'h0, 32'h0, 32'h0, 1'b0, 4'b1111}) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%0b rd=%0b wr=%0b addr=%h din=%h cfg=%h irq=%0b size=%b",
               o_req, o_bus_read, o_bus_write, o_bus_addr, o_bus_din, o_cfg_dout, o_irq,
               o_bus_size);
    end
    i_rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      cfg_read(32'(4 * r), d);
      n_cmp++;
      if (d !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_reg[%0d]: got %h want 00000000", r, d);
      end
    end
    n_cmp++;
    if ({o_req, o_irq} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_req_irq: got req=%0b irq=%0b want 0 0", o_req, o_irq);
    end
  endtask

  task automatic check_scoreboard(input string name);
    xact_t e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs_rd >= obs_q.size()) begin
        n_fail++;
        $display("FAIL %s_missing: got none want wr=%0b addr=%h data=%h", name, e.wr, e.addr,
                 e.data);
      end else begin
        o = obs_q[obs_rd];
        obs_rd++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL %s_xact: got wr=%0b addr=%h data=%h want wr=%0b addr=%h data=%h",
                   name, o.wr, o.addr, o.data, e.wr, e.addr, e.data);
        end
      end
    end
    n_cmp++;
    if (obs_q.size() != obs_rd) begin
      n_fail++;
      $display("FAIL %s_extra: got %0d accesses want %0d", name, obs_q.size(), obs_rd);
      obs_rd = obs_q.size();
    end
  endtask

  task automatic test_copy;
    logic [31:0] d;
    int cyc;
    i_gnt = 1'b1;
    cfg_write(32'h0, 32'h0000_1003);
    cfg_write(32'h4, 32'h0000_1100);
    cfg_write(32'h8, 32'habcd_0004);
    cfg_read(32'h0, d);
    n_cmp++;
    if (d !== 32'h0000_1000) begin
      n_fail++; $display("FAIL src_align: got %h want 00001000", d);
    end
    cfg_read(32'h8, d);
    n_cmp++;
    if (d !== 32'h0000_0004) begin
      n_fail++; $display("FAIL len_mask: got %h want 00000004", d);
    end
    push_copy(32'h1000, 32'h1100, 4);
    cfg_write(32'hc, 32'h1);
    wait_done(cyc);
    n_cmp++;
    if (cyc != 12) begin
      n_fail++; $display("FAIL copy_busy_cycles: got %0d want 12", cyc);
    end
    check_scoreboard("copy");
    cfg_read(32'hc, d);
    n_cmp++;
    if (d !== 32'h2) begin
      n_fail++; $display("FAIL copy_status: got %h want 00000002", d);
    end
    cfg_read(32'h0, d);
    n_cmp++;
    if (d !== 32'h0000_1000) begin
      n_fail++; $display("FAIL copy_src_kept: got %h want 00001000", d);
    end
  endtask

  task automatic test_stall;
    int k;
    i_gnt = 1'b0;
    push_copy(32'h1000, 32'h1100, 4);
    cfg_write(32'hc, 32'h1);
    k = 1;
    while (!o_irq && k < 60) begin
      i_gnt = !(k <= 5 || k == 11 || k == 12);
      if (k <= 5) begin
        n_cmp++;
        if ({o_req, o_bus_read, o_bus_write, o_bus_addr} !== {3'b110, 32'h1000}) begin
          n_fail++;
          $display("FAIL stall_rd[%0d]: got req=%0b rd=%0b wr=%0b addr=%h want 1 1 0 00001000",
                   k, o_req, o_bus_read, o_bus_write, o_bus_addr);
        end
      end else if (k == 11 || k == 12) begin
        n_cmp++;
        if ({o_req, o_bus_read, o_bus_write, o_bus_addr, o_bus_din}
            !== {3'b101, 32'h1104, src_word(32'h1004)}) begin
          n_fail++;
          $display("FAIL stall_wr[%0d]: got req=%0b rd=%0b wr=%0b addr=%h din=%h", k, o_req,
                   o_bus_read, o_bus_write, o_bus_addr, o_bus_din);
        end
      end
      @(negedge i_clk);
      k++;
    end
    i_gnt = 1'b1;
    n_cmp++;
    if (k - 1 != 19) begin
      n_fail++; $display("FAIL stall_busy_cycles: got %0d want 19", k - 1);
    end
    check_scoreboard("stall");
  endtask

  task automatic test_len_zero;
    logic [31:0] d;
    logic saw_req;
    cfg_write(32'h8, 32'h0);
    cfg_write(32'hc, 32'h1);
    n_cmp++;
    if ({o_irq, o_req} !== 2'b10) begin
      n_fail++; $display("FAIL len0_done: got irq=%0b req=%0b want 1 0", o_irq, o_req);
    end
    saw_req = 1'b0;
    repeat (4) begin
      @(negedge i_clk);
      saw_req |= o_req;
    end
    n_cmp++;
    if (saw_req !== 1'b0) begin
      n_fail++; $display("FAIL len0_no_req: got req seen=%0b want 0", saw_req);
    end
    cfg_read(32'hc, d);
    n_cmp++;
    if (d !== 32'h2) begin
      n_fail++; $display("FAIL len0_status: got %h want 00000002", d);
    end
    cfg_write(32'hc, 32'h2);
    n_cmp++;
    if (o_irq !== 1'b0) begin
      n_fail++; $display("FAIL len0_clear_irq: got %0b want 0", o_irq);
    end
    cfg_read(32'hc, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL len0_clear_status: got %h want 00000000", d);
    end
    check_scoreboard("len0");
  endtask

  task automatic test_busy_ignore;
    logic [31:0] d;
    int cyc;
    i_gnt = 1'b1;
    cfg_write(32'h0, 32'h3000);
    cfg_write(32'h4, 32'h3100);
    cfg_write(32'h8, 32'h2);
    push_copy(32'h3000, 32'h3100, 2);
    cfg_write(32'hc, 32'h1);
    cfg_write(32'h0, 32'h2000);
    cfg_write(32'hc, 32'h1);
    wait_done(cyc);
    repeat (8) @(negedge i_clk);
    check_scoreboard("busy_ignore");
    cfg_read(32'h0, d);
    n_cmp++;
    if (d !== 32'h3000) begin
      n_fail++; $display("FAIL busy_src_kept: got %h want 00003000", d);
    end
    cfg_read(32'hc, d);
    n_cmp++;
    if (d !== 32'h2) begin
      n_fail++; $display("FAIL busy_status: got %h want 00000002", d);
    end
  endtask

  task automatic test_wrap;
    int cyc;
    i_gnt = 1'b1;
    cfg_write(32'h0, 32'hffff_fffc);
    cfg_write(32'h4, 32'h0000_0040);
    push_copy(32'hffff_fffc, 32'h0000_0040, 2);
    cfg_write(32'hc, 32'h3);
    wait_done(cyc);
    n_cmp++;
    if (cyc != 6) begin
      n_fail++; $display("FAIL wrap_busy_cycles: got %0d want 6", cyc);
    end
    check_scoreboard("wrap");
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic saw_req;
    i_gnt = 1'b1;
    cfg_write(32'h0, 32'h500);
    cfg_write(32'h4, 32'h600);
    cfg_write(32'h8, 32'h3);
    exp_q.push_back('{wr: 1'b0, addr: 32'h500, data: 32'h0});
    cfg_write(32'hc, 32'h1);
    @(negedge i_clk);
    i_gnt = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if ({o_req, o_bus_write, o_bus_addr} !== {2'b11, 32'h600}) begin
      n_fail++;
      $display("FAIL rstmid_in_wr: got req=%0b wr=%0b addr=%h want 1 1 00000600", o_req,
               o_bus_write, o_bus_addr);
    end
    #2 i_rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_req, o_bus_read, o_bus_write} !== 3'b000) begin
      n_fail++;
      $display("FAIL rstmid_req_drop: got req=%0b rd=%0b wr=%0b want 0 0 0", o_req, o_bus_read,
               o_bus_write);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_gnt   = 1'b1;
    saw_req = 1'b0;
    repeat (10) begin
      @(negedge i_clk);
      saw_req |= o_req;
    end
    n_cmp++;
    if (saw_req !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_activity: got req seen=%0b want 0", saw_req);
    end
    cfg_read(32'hc, d);
    n_cmp++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_status: got %h want 00000000", d);
    end
    check_scoreboard("rstmid");
  endtask

  initial begin
    test_reset();
    test_copy();
    test_stall();
    test_len_zero();
    test_busy_ignore();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
